// File: rtl/an_pkg.sv
// an_pkg: shared defaults, quotient-width trim and FSM states for the AN-code checker.
package an_pkg;
  localparam int A_DEF    = 61;
  localparam int CW_W_DEF = 29;
  localparam int N_CW_DEF = 10;
  localparam int Q_TRIM   = 6;
  localparam int QW_DEF   = CW_W_DEF - Q_TRIM;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
endpackage

// File: rtl/an_residue_unit.sv
// an_residue_unit: combinational residue mod A and truncated quotient of one codeword.
// Quotient datapath is built only when AN_DECODE_EN is defined.
module an_residue_unit
  import an_pkg::*;
#(
  parameter int CW_W = CW_W_DEF,
  parameter int A    = A_DEF
) (
  input  logic [CW_W-1:0]        cw,
  output logic [CW_W-1:0]        res,
  output logic [CW_W-Q_TRIM-1:0] quo
);
  localparam int QW = CW_W - Q_TRIM;
  localparam logic [CW_W-1:0] AW = CW_W'(A);
  logic [CW_W-1:0] r;
`ifdef AN_DECODE_EN
  logic [QW-1:0] q;
`endif
  // Restoring long division; shifting q left keeps only the low QW quotient bits.
  always_comb begin
    r = '0;
`ifdef AN_DECODE_EN
    q = '0;
`endif
    for (int i = CW_W - 1; i >= 0; i--) begin
      r = {r[CW_W-2:0], cw[i]};
`ifdef AN_DECODE_EN
      q = {q[QW-2:0], r >= AW};
`endif
      r = (r >= AW) ? r - AW : r;
    end
  end
  assign res = r;
`ifdef AN_DECODE_EN
  assign quo = q;
`else
  assign quo = '0;
`endif
endmodule

// File: rtl/an_codeword_checker.sv
// an_codeword_checker: checks one AN-coded frame lane per cycle, flags non-multiples of A.
// Define AN_DECODE_EN to also produce the decoded quotients.
module an_codeword_checker
  import an_pkg::*;
#(
  parameter int CW_W = CW_W_DEF,
  parameter int N_CW = N_CW_DEF,
  parameter int A    = A_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CW_W*N_CW-1:0]            layer_in,
  input  logic                            valid,
  output logic [CW_W*N_CW-1:0]            layer_out,
  output logic [N_CW-1:0]                 err_mask,
  output logic [3:0]                      err_cnt,
  output logic [(CW_W-Q_TRIM)*N_CW-1:0]   decoded,
  output logic                            ready
);
  localparam int QW = CW_W - Q_TRIM;
  localparam int IW = (N_CW > 1) ? $clog2(N_CW) : 1;
  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW_W-1:0] lane;
  logic [CW_W-1:0] res;
  logic [QW-1:0]   quo;
  logic            err;
  logic            last;
  assign lane = layer_out[idx*CW_W +: CW_W];
  assign err  = |res;
  assign last = idx == IW'(N_CW - 1);
  an_residue_unit #(.CW_W(CW_W), .A(A)) u_res (
    .cw  (lane),
    .res (res),
    .quo (quo)
  );
  // ready is registered on leaving DONE, giving the N_CW+1 cycle valid-to-ready latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      layer_out <= '0;
      err_mask  <= '0;
      err_cnt   <= '0;
      decoded   <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          layer_out <= layer_in;
          err_mask  <= '0;
          err_cnt   <= '0;
          decoded   <= '0;
          idx       <= '0;
          state     <= CHECK;
        end
        CHECK: begin
          err_mask[idx]         <= err;
          decoded[idx*QW +: QW] <= quo;
          err_cnt               <= (err_cnt == 4'hf) ? err_cnt : err_cnt + {3'b0, err};
          idx                   <= last ? '0 : idx + 1'b1;
          state                 <= last ? DONE : CHECK;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
